// File: rtl/ex_wb_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_wb_stage_pkg                                              |
// | Description : Shared encodings for the execute/writeback stage: ALU,       |
// |               branch and load/store func3 values, memory FSM states,       |
// |               byte-lane masks and lane steering helpers.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ex_wb_stage_pkg;

    // Memory-access state machine
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RWAIT = 2'd2
    } state_t;

    // ALU func3
    localparam logic [2:0] C_F3_ADD  = 3'b000;
    localparam logic [2:0] C_F3_SLL  = 3'b001;
    localparam logic [2:0] C_F3_SLT  = 3'b010;
    localparam logic [2:0] C_F3_SLTU = 3'b011;
    localparam logic [2:0] C_F3_XOR  = 3'b100;
    localparam logic [2:0] C_F3_SR   = 3'b101;
    localparam logic [2:0] C_F3_OR   = 3'b110;
    localparam logic [2:0] C_F3_AND  = 3'b111;

    // Branch func3 (010/011 are illegal)
    localparam logic [2:0] C_F3_BEQ  = 3'b000;
    localparam logic [2:0] C_F3_BNE  = 3'b001;
    localparam logic [2:0] C_F3_BLT  = 3'b100;
    localparam logic [2:0] C_F3_BGE  = 3'b101;
    localparam logic [2:0] C_F3_BLTU = 3'b110;
    localparam logic [2:0] C_F3_BGEU = 3'b111;

    // Load/store func3 (stores use the same low two bits)
    localparam logic [2:0] C_F3_LB   = 3'b000;
    localparam logic [2:0] C_F3_LH   = 3'b001;
    localparam logic [2:0] C_F3_LW   = 3'b010;
    localparam logic [2:0] C_F3_LBU  = 3'b100;
    localparam logic [2:0] C_F3_LHU  = 3'b101;

    // Access size is carried in func3[1:0]
    localparam logic [1:0] C_SZ_B    = 2'b00;
    localparam logic [1:0] C_SZ_H    = 2'b01;
    localparam logic [1:0] C_SZ_W    = 2'b10;

    // Byte-lane masks before shifting to the addressed lane
    localparam logic [3:0] C_MASK_B  = 4'b0001;
    localparam logic [3:0] C_MASK_H  = 4'b0011;
    localparam logic [3:0] C_MASK_W  = 4'b1111;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            C_SZ_H:  return off[0];
            C_SZ_W:  return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            C_SZ_B:  return 4'(C_MASK_B << off);
            C_SZ_H:  return 4'(C_MASK_H << off);
            default: return C_MASK_W;
        endcase
    endfunction

    // Replicate the store datum across all lanes; the mask picks the live one
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            C_SZ_B:  return {4{d[7:0]}};
            C_SZ_H:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            C_F3_LB:  return {{24{sh[7]}}, sh[7:0]};
            C_F3_LH:  return {{16{sh[15]}}, sh[15:0]};
            C_F3_LBU: return {24'h0, sh[7:0]};
            C_F3_LHU: return {16'h0, sh[15:0]};
            default:  return rdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_wb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_wb_stage_if                                               |
// | Description : Data-memory valid/ready request bus with load return.        |
// |   master (core): dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask out; |
// |                  dmem_ready, dmem_rvalid, dmem_rdata in                    |
// |   slave (memory): the reverse                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ex_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ex_wb_stage_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_wb_stage_alu                                              |
// | Description : Combinational RV32I ALU plus branch comparator.              |
// |   op_a, op_b : operands       func3/subtype : operation select            |
// |   result     : ALU result     taken         : branch condition (func3)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_wb_stage_alu
    import ex_wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [2:0]      func3,
    input  logic            subtype,
    output logic [XLEN-1:0] result,
    output logic            taken
);
    logic [4:0] w_shamt;
    logic       w_eq;
    logic       w_lt;
    logic       w_ltu;

    assign w_shamt = op_b[4:0];
    assign w_eq    = (op_a == op_b);
    assign w_lt    = ($signed(op_a) < $signed(op_b));
    assign w_ltu   = (op_a < op_b);

    always_comb begin
        result = '0;
        case (func3)
            C_F3_ADD:  result = subtype ? (op_a - op_b) : (op_a + op_b);
            C_F3_SLL:  result = op_a << w_shamt;
            C_F3_SLT:  result = {{(XLEN-1){1'b0}}, w_lt};
            C_F3_SLTU: result = {{(XLEN-1){1'b0}}, w_ltu};
            C_F3_XOR:  result = op_a ^ op_b;
            C_F3_SR:   result = subtype ? XLEN'($signed(op_a) >>> w_shamt) : (op_a >> w_shamt);
            C_F3_OR:   result = op_a | op_b;
            C_F3_AND:  result = op_a & op_b;
            default:   result = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (func3)
            C_F3_BEQ:  taken = w_eq;
            C_F3_BNE:  taken = !w_eq;
            C_F3_BLT:  taken = w_lt;
            C_F3_BGE:  taken = !w_lt;
            C_F3_BLTU: taken = w_ltu;
            C_F3_BGEU: taken = !w_ltu;
            default:   taken = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_wb_stage                                                  |
// | Description : Execute/writeback stage of the 3-stage RV32I core. Owns the  |
// |               32x32 register file, ALU, branch/jump resolution and the     |
// |               data-memory FSM; stalls and redirects the decode stage.      |
// |   clk, reset (async, active low)                                           |
// |   id_*           : registered decode bundle from the upstream stage        |
// |   ex_stall       : upstream holds        ex_flush/ex_redirect_pc : redirect|
// |   exception      : sticky fault          instret : retired count           |
// |   dmem           : data-memory master port                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_wb_stage
    import ex_wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int          XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_imm_sel,
    input  logic            id_alu,
    input  logic            id_lui,
    input  logic            id_jal,
    input  logic            id_jalr,
    input  logic            id_branch,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_func3,
    input  logic            id_subtype,
    output logic            ex_stall,
    output logic            ex_flush,
    output logic [XLEN-1:0] ex_redirect_pc,
    output logic            exception,
    output logic [XLEN-1:0] instret,
    ex_wb_stage_if.master   dmem
);
    state_t          r_state;
    logic [XLEN-1:0] r_regs [32];
    logic            r_flush;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_exception;
    logic [XLEN-1:0] r_instret;
    logic            r_req;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wmask;
    logic [4:0]      r_rd;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;

    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_res;
    logic            w_taken;
    logic            w_accept;
    logic            w_is_mem;
    logic [XLEN-1:0] w_mem_addr;
    logic            w_bad_branch;
    logic            w_misalign;
    logic            w_fault;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc4;
    logic            w_accept_wb;
    logic [XLEN-1:0] w_wb_data;
    logic            w_load_done;
    logic            w_store_done;
    logic            w_retire;
    logic            w_rf_we;
    logic [4:0]      w_rf_waddr;
    logic [XLEN-1:0] w_rf_wdata;

    // x0 is hardwired to zero on the read side
    assign w_rs1 = (id_rs1 == 5'd0) ? '0 : r_regs[id_rs1];
    assign w_rs2 = (id_rs2 == 5'd0) ? '0 : r_regs[id_rs2];

    // Branches always compare rs1 against rs2 regardless of imm_sel
    assign w_op_b = (id_imm_sel && !id_branch) ? id_imm : w_rs2;

    ex_wb_stage_alu #(.XLEN(XLEN)) u_alu (
        .op_a    (w_rs1),
        .op_b    (w_op_b),
        .func3   (id_func3),
        .subtype (id_subtype),
        .result  (w_alu_res),
        .taken   (w_taken)
    );

    // The cycle after a redirect carries a wrong-path bundle, so it is refused
    assign w_accept     = id_valid && (r_state == ST_IDLE) && !r_flush && !r_exception;
    assign w_is_mem     = id_mem_write || id_mem_to_reg;
    assign w_mem_addr   = w_rs1 + id_imm;
    assign w_pc4        = id_pc + XLEN'(4);
    assign w_bad_branch = id_branch && (id_func3 == 3'b010 || id_func3 == 3'b011);
    assign w_misalign   = w_is_mem && misaligned(id_func3[1:0], w_mem_addr[1:0]);
    assign w_fault      = w_accept && (w_bad_branch || w_misalign);

    assign w_redirect   = w_accept && !w_is_mem &&
                          (id_jal || id_jalr || (id_branch && w_taken));
    // JALR shares the rs1+imm adder with the load/store address path
    assign w_target     = id_jalr ? {w_mem_addr[XLEN-1:1], 1'b0} : (id_pc + id_imm);

    assign w_accept_wb  = w_accept && !w_is_mem && !id_branch &&
                          (id_alu || id_lui || id_jal || id_jalr);
    assign w_wb_data    = (id_jal || id_jalr) ? w_pc4 : (id_lui ? id_imm : w_alu_res);

    // A load may be answered in the same cycle it is accepted
    assign w_load_done  = ((r_state == ST_REQ) && dmem.dmem_ready && !r_we && dmem.dmem_rvalid) ||
                          ((r_state == ST_RWAIT) && dmem.dmem_rvalid);
    assign w_store_done = (r_state == ST_REQ) && dmem.dmem_ready && r_we;
    assign w_retire     = (w_accept && !w_is_mem && !w_bad_branch) || w_load_done || w_store_done;

    // Load completion and single-cycle writeback are mutually exclusive:
    // the former only happens outside IDLE, the latter only inside it.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = '0;
        w_rf_wdata = '0;
        if (w_load_done) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = r_rd;
            w_rf_wdata = load_extract(r_f3, r_off, dmem.dmem_rdata);
        end else if (w_accept_wb) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = id_rd;
            w_rf_wdata = w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
            r_regs[w_rf_waddr] <= w_rf_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= RESET;
            r_exception   <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_flush     <= w_redirect;
            r_exception <= r_exception || w_fault;
            r_instret   <= r_instret + XLEN'(w_retire);
            if (w_redirect) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    // Memory FSM with registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rd    <= '0;
            r_f3    <= '0;
            r_off   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mem && !w_misalign) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_we    <= id_mem_write;
                        r_addr  <= {w_mem_addr[XLEN-1:2], 2'b00};
                        r_wdata <= store_data(id_func3[1:0], w_rs2);
                        r_wmask <= id_mem_write ? store_mask(id_func3[1:0], w_mem_addr[1:0]) : 4'b0000;
                        r_rd    <= id_rd;
                        r_f3    <= id_func3;
                        r_off   <= w_mem_addr[1:0];
                    end
                end
                ST_REQ: begin
                    if (dmem.dmem_ready) begin
                        r_req <= 1'b0;
                        if (r_we || dmem.dmem_rvalid) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_RWAIT;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (dmem.dmem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign ex_stall        = (r_state != ST_IDLE);
    assign ex_flush        = r_flush;
    assign ex_redirect_pc  = r_redirect_pc;
    assign exception       = r_exception;
    assign instret         = r_instret;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wmask = r_wmask;
endmodule
`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_wb_stage                                               |
// | Description : Self-checking bench for ex_wb_stage. Register contents are   |
// |               observed by storing them (SW rN,0(x0)); expected store data  |
// |               is queued when the store is issued and compared when the     |
// |               bus handshake completes.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ex_wb_stage;
    localparam int K_ALU = 0, K_LUI = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_ST = 5, K_LD = 6;

    typedef struct {
        logic [2:0]  f3;
        logic        sub;
        logic        isel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid, id_imm_sel, id_alu, id_lui, id_jal, id_jalr, id_branch;
    logic        id_mem_write, id_mem_to_reg, id_subtype;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_func3;
    logic        ex_stall, ex_flush, exception;
    logic [31:0] ex_redirect_pc, instret;

    ex_wb_stage_if bus();

    ex_wb_stage #(.RESET(32'h0000_0000), .XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_imm         (id_imm),
        .id_imm_sel     (id_imm_sel),
        .id_alu         (id_alu),
        .id_lui         (id_lui),
        .id_jal         (id_jal),
        .id_jalr        (id_jalr),
        .id_branch      (id_branch),
        .id_mem_write   (id_mem_write),
        .id_mem_to_reg  (id_mem_to_reg),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_func3       (id_func3),
        .id_subtype     (id_subtype),
        .ex_stall       (ex_stall),
        .ex_flush       (ex_flush),
        .ex_redirect_pc (ex_redirect_pc),
        .exception      (exception),
        .instret        (instret),
        .dmem           (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ir = 32'd0;
    sb_t         sb_q[$];
    vec_t        vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed store handshake pops one expected value
    always @(negedge clk) begin
        sb_t e;
        if (bus.dmem_req && bus.dmem_we && bus.dmem_ready && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, bus.dmem_wdata, e.val);
        end
    end

    task automatic idle();
        id_valid = 0; id_alu = 0; id_lui = 0; id_jal = 0; id_jalr = 0; id_branch = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_imm_sel = 0; id_subtype = 0;
        id_func3 = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_imm = 0; id_pc = 0;
    endtask

    task automatic put(input int kind, input logic [2:0] f3, input logic sub, input logic isel,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
        id_valid = 1; id_alu = (kind == K_ALU); id_lui = (kind == K_LUI);
        id_jal = (kind == K_JAL); id_jalr = (kind == K_JALR); id_branch = (kind == K_BR);
        id_mem_write = (kind == K_ST); id_mem_to_reg = (kind == K_LD);
        id_func3 = f3; id_subtype = sub; id_imm_sel = isel;
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_imm = imm; id_pc = pc;
    endtask

    task automatic exec(input int kind, input logic [2:0] f3, input logic sub, input logic isel,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc);
        put(kind, f3, sub, isel, rd, rs1, rs2, imm, pc);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic lui(input logic [4:0] rd, input logic [31:0] val);
        exec(K_LUI, 3'b000, 0, 1, rd, 5'd0, 5'd0, val, 32'h0);
        exp_ir++;
    endtask

    // SW rN,0(x0) with an immediately-ready memory; the scoreboard compares wdata
    task automatic peek(input logic [4:0] idx, input logic [31:0] exp, input string name);
        sb_q.push_back('{name, exp});
        exec(K_ST, 3'b010, 0, 1, 5'd0, 5'd0, idx, 32'h0, 32'h0);
        bus.dmem_ready = 1;
        @(posedge clk); #1;
        bus.dmem_ready = 0;
        exp_ir++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int stall_cnt;
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       "add"};
        vecs[1]  = '{3'b000, 1'b1, 1'b0, 32'd5,        32'd7,        32'hFFFFFFFE, "sub"};
        vecs[2]  = '{3'b001, 1'b0, 1'b0, 32'd1,        32'h23,       32'd8,        "sll_shamt5"};
        vecs[3]  = '{3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        "slt"};
        vecs[4]  = '{3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        "sltu"};
        vecs[5]  = '{3'b100, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, "xor"};
        vecs[6]  = '{3'b101, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'h08000000, "srl"};
        vecs[7]  = '{3'b101, 1'b1, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, "sra"};
        vecs[8]  = '{3'b110, 1'b0, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, "or"};
        vecs[9]  = '{3'b111, 1'b0, 1'b0, 32'h000000F0, 32'h0000003C, 32'h00000030, "and"};
        vecs[10] = '{3'b000, 1'b0, 1'b1, 32'd5,        32'hFFFFFFFF, 32'd4,        "addi_neg"};
        vecs[11] = '{3'b010, 1'b0, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'd1,        "slti"};

        idle();
        bus.dmem_ready = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",    32'(ex_stall), 32'd0);
        check("rst_flush",    32'(ex_flush), 32'd0);
        check("rst_redirect", ex_redirect_pc, 32'h0);
        check("rst_exc",      32'(exception), 32'd0);
        check("rst_instret",  instret, 32'd0);
        check("rst_req",      32'(bus.dmem_req), 32'd0);
        check("rst_wmask",    32'(bus.dmem_wmask), 32'd0);
        reset = 1;

        // ADDI x1,x0,5 ; SUB x2,x1,x1
        exec(K_ALU, 3'b000, 0, 1, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0);
        exp_ir++;
        exec(K_ALU, 3'b000, 1, 0, 5'd2, 5'd1, 5'd1, 32'd0, 32'h4);
        exp_ir++;
        check("addsub_instret", instret, 32'd2);
        check("addsub_stall",   32'(ex_stall), 32'd0);
        peek(5'd1, 32'd5, "x1_addi");
        peek(5'd2, 32'd0, "x2_sub");

        // ALU table
        for (int i = 0; i < 12; i++) begin
            lui(5'd1, vecs[i].a);
            lui(5'd2, vecs[i].b);
            exec(K_ALU, vecs[i].f3, vecs[i].sub, vecs[i].isel, 5'd3, 5'd1, 5'd2, vecs[i].b, 32'h0);
            exp_ir++;
            peek(5'd3, vecs[i].exp, vecs[i].name);
        end

        // BEQ x0,x0,+8 at 0x10; the bundle offered in the flush cycle is dropped
        exec(K_BR, 3'b000, 0, 0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h10);
        exp_ir++;
        check("beq_flush",    32'(ex_flush), 32'd1);
        check("beq_redirect", ex_redirect_pc, 32'h18);
        put(K_LUI, 3'b000, 0, 1, 5'd5, 5'd0, 5'd0, 32'hDEAD, 32'h14);
        @(posedge clk); #1;
        idle();
        check("beq_flush_1cyc", 32'(ex_flush), 32'd0);
        check("beq_instret",    instret, exp_ir);
        peek(5'd5, 32'd0, "wrong_path_dropped");

        // Not-taken BNE
        exec(K_BR, 3'b001, 0, 0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h30);
        exp_ir++;
        check("bne_nt_flush", 32'(ex_flush), 32'd0);

        // Signed vs unsigned compare on -1 vs 1
        lui(5'd1, 32'hFFFFFFFF);
        lui(5'd2, 32'd1);
        exec(K_BR, 3'b110, 0, 0, 5'd0, 5'd1, 5'd2, 32'h10, 32'h50);
        exp_ir++;
        check("bltu_nt_flush", 32'(ex_flush), 32'd0);
        exec(K_BR, 3'b100, 0, 0, 5'd0, 5'd1, 5'd2, 32'h10, 32'h50);
        exp_ir++;
        check("blt_flush",    32'(ex_flush), 32'd1);
        check("blt_redirect", ex_redirect_pc, 32'h60);
        @(posedge clk); #1;

        // JALR x1,x2,3 with x2=0x100 at 0x20
        lui(5'd2, 32'h100);
        exec(K_JALR, 3'b000, 0, 1, 5'd1, 5'd2, 5'd0, 32'd3, 32'h20);
        exp_ir++;
        check("jalr_flush",    32'(ex_flush), 32'd1);
        check("jalr_redirect", ex_redirect_pc, 32'h102);
        @(posedge clk); #1;
        peek(5'd1, 32'h24, "jalr_link");

        // JAL x6,-8 at 0x40
        exec(K_JAL, 3'b000, 0, 1, 5'd6, 5'd0, 5'd0, 32'hFFFFFFF8, 32'h40);
        exp_ir++;
        check("jal_redirect", ex_redirect_pc, 32'h38);
        @(posedge clk); #1;
        peek(5'd6, 32'h44, "jal_link");

        // SB x3,1(x0), memory ready in the third request cycle
        lui(5'd3, 32'hAB);
        exec(K_ST, 3'b000, 0, 1, 5'd0, 5'd0, 5'd3, 32'd1, 32'h0);
        check("sb_req",   32'(bus.dmem_req), 32'd1);
        check("sb_we",    32'(bus.dmem_we), 32'd1);
        check("sb_addr",  bus.dmem_addr, 32'h0);
        check("sb_wmask", 32'(bus.dmem_wmask), 32'b0010);
        check("sb_wdata", bus.dmem_wdata, 32'hABABABAB);
        stall_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (ex_stall) stall_cnt++;
            bus.dmem_ready = (k == 2);
            @(posedge clk); #1;
        end
        bus.dmem_ready = 0;
        exp_ir++;
        check("sb_stall_cycles", 32'(stall_cnt), 32'd3);
        check("sb_stall_end",    32'(ex_stall), 32'd0);
        check("sb_req_end",      32'(bus.dmem_req), 32'd0);

        // SH x3,2(x0): upper halfword lanes
        exec(K_ST, 3'b001, 0, 1, 5'd0, 5'd0, 5'd3, 32'd2, 32'h0);
        check("sh_wmask", 32'(bus.dmem_wmask), 32'b1100);
        check("sh_wdata", bus.dmem_wdata, 32'h00AB00AB);
        bus.dmem_ready = 1;
        @(posedge clk); #1;
        bus.dmem_ready = 0;
        exp_ir++;

        // LH x4,2(x0), rvalid two cycles after ready
        exec(K_LD, 3'b001, 0, 1, 5'd4, 5'd0, 5'd0, 32'd2, 32'h0);
        check("lh_req",  32'(bus.dmem_req), 32'd1);
        check("lh_we",   32'(bus.dmem_we), 32'd0);
        check("lh_addr", bus.dmem_addr, 32'h0);
        bus.dmem_ready = 1;
        @(posedge clk); #1;
        bus.dmem_ready = 0;
        check("lh_rwait_stall", 32'(ex_stall), 32'd1);
        check("lh_rwait_req",   32'(bus.dmem_req), 32'd0);
        @(posedge clk); #1;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h8001_0000;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        exp_ir++;
        check("lh_done_stall", 32'(ex_stall), 32'd0);
        peek(5'd4, 32'hFFFF8001, "lh_sext");

        // LBU x7,3(x0) answered in the request cycle
        exec(K_LD, 3'b100, 0, 1, 5'd7, 5'd0, 5'd0, 32'd3, 32'h0);
        bus.dmem_ready = 1; bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h8001_0000;
        @(posedge clk); #1;
        bus.dmem_ready = 0; bus.dmem_rvalid = 0;
        exp_ir++;
        check("lbu_direct_stall", 32'(ex_stall), 32'd0);
        peek(5'd7, 32'h80, "lbu_zext");
        check("instret_mem", instret, exp_ir);

        // Misaligned LW at 0x6: sticky exception, nothing retires afterwards
        exec(K_LD, 3'b010, 0, 1, 5'd1, 5'd0, 5'd0, 32'd6, 32'h0);
        check("lw_mis_exc",     32'(exception), 32'd1);
        check("lw_mis_req",     32'(bus.dmem_req), 32'd0);
        check("lw_mis_stall",   32'(ex_stall), 32'd0);
        check("lw_mis_instret", instret, exp_ir);
        exec(K_LUI, 3'b000, 0, 1, 5'd9, 5'd0, 5'd0, 32'h1234, 32'h0);
        check("exc_blocks_accept", instret, exp_ir);

        reset = 0;
        #1;
        check("rst_clears_exc", 32'(exception), 32'd0);
        @(posedge clk); #1;
        reset = 1;
        exp_ir = 0;

        // Reset asserted while a store is in REQ
        exec(K_ALU, 3'b000, 0, 1, 5'd1, 5'd0, 5'd0, 32'd9, 32'h0);
        exec(K_ST, 3'b010, 0, 1, 5'd0, 5'd0, 5'd1, 32'd4, 32'h0);
        check("pre_rst_req", 32'(bus.dmem_req), 32'd1);
        #2;
        reset = 0;
        #1;
        check("midreq_req",     32'(bus.dmem_req), 32'd0);
        check("midreq_stall",   32'(ex_stall), 32'd0);
        check("midreq_wmask",   32'(bus.dmem_wmask), 32'd0);
        check("midreq_wdata",   bus.dmem_wdata, 32'h0);
        check("midreq_instret", instret, 32'd0);
        @(posedge clk); #1;
        reset = 1;
        peek(5'd1, 32'd0, "x1_cleared_by_reset");

        // Illegal branch func3
        exec(K_BR, 3'b010, 0, 0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h70);
        check("badbr_exc",     32'(exception), 32'd1);
        check("badbr_flush",   32'(ex_flush), 32'd0);
        check("badbr_instret", instret, exp_ir);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
Execute/writeback stage of the three-stage RV32I core. It sits directly downstream of the fetch/decode stage and consumes its registered decode bundle. It reads and writes the 32x32 register file, performs ALU ops, resolves branches and jumps, runs loads and stores over a valid/ready data-memory handshake, and back-pressures and redirects the upstream stage.

Parameters:
RESET, 32'h0000_0000, PC value restored on reset (matches upstream)
XLEN, 32, datapath width; only 32 is supported

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decode bundle valid this cycle
id_pc  in  32  PC of the decoded instruction
id_imm  in  32  decoded immediate
id_imm_sel  in  1  operand B = imm (else rs2)
id_alu / id_lui / id_jal / id_jalr / id_branch  in  1 each  instruction class
id_mem_write / id_mem_to_reg  in  1 each  store / load
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_func3  in  3  func3
id_subtype  in  1  SUB/SRA select
ex_stall  out  1  upstream must hold its register contents
ex_flush  out  1  one-cycle redirect pulse
ex_redirect_pc  out  32  fetch target, valid when ex_flush=1
exception  out  1  sticky fault flag
instret  out  32  retired-instruction counter
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address
dmem_wdata  out  32  lane-replicated store data
dmem_wmask  out  4  byte enables
dmem_ready  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load data word

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all registers 0; ex_redirect_pc = RESET. x0 always reads 0 and writes to it are dropped.
- Accept: in IDLE with ex_stall=0 and ex_flush=0, id_valid=1 accepts the bundle. Register reads are combinational; no bypass is required.
- ALU path (id_alu, id_lui, jumps) completes in the accept cycle; rd is written at that edge.
- ALU by func3:
  - 000: ADD, or SUB if subtype.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA if subtype.
  - 110: OR.
  - 111: AND.
  - Shift amount is operand B[4:0]. LUI writes imm.
- Branch func3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. 010/011 set exception, with no writeback.
- Redirect targets:
  - Taken branch and JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - JAL/JALR write pc+4 to rd.
- Redirect timing: on the next cycle ex_flush=1 for exactly one cycle with the target on ex_redirect_pc. Any bundle offered during that cycle is the wrong path and is ignored (not retired).
- Memory FSM:
  - IDLE: on an accepted load/store, compute addr=rs1+imm.
    - Misaligned (LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0): set exception, retire nothing, stay IDLE.
    - Otherwise latch fields and go to REQ.
  - REQ: dmem_req=1, fields stable until dmem_ready.
    - Store + ready: IDLE.
    - Load + ready: go to RWAIT. If dmem_rvalid is seen in the same cycle, complete directly.
  - RWAIT: on dmem_rvalid, select the lane by addr[1:0], sign/zero-extend per func3 (LB 000, LH 001, LW 010, LBU 100, LHU 101), write rd, go to IDLE.
- Store lanes: SB mask 0001<<a[1:0] with data {4{b}}; SH mask 0011<<a[1:0] with data {2{h}}; SW mask 1111.
- ex_stall = (state != IDLE). The instruction on the id_* inputs is accepted in the first IDLE cycle after completion.
- instret increments by 1 per retired instruction and wraps at 2^32.
- exception is sticky until reset. Once set, no further instructions are accepted and FSM/stall/flush behave as IDLE.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, dmem_req drops, and there is no partial writeback.

Decomposition:
- Shared package/header (opcode.vh): func3 encodings (ALU, branch, load/store), state encodings IDLE/REQ/RWAIT, lane-mask constants.
- One natural sub-module: ex_alu, a combinational ALU plus branch comparator taking op A, op B, func3, subtype and producing result and taken.

Test Plan:
- ADDI x1,x0,5 then SUB x2,x1,x1 with subtype -> x1=5, x2=0, instret=2, no stall.
- BEQ x0,x0,+8 at pc=0x10 -> ex_flush=1 for 1 cycle, ex_redirect_pc=0x18; next offered bundle dropped; instret +1.
- JALR x1,x2,3 with x2=0x100 at pc=0x20 -> redirect 0x102, x1=0x24.
- SB x3,1(x0) with x3=0xAB, dmem_ready after 3 cycles -> dmem_wmask=0010, wdata=0xABABABAB, addr=0, ex_stall=1 for 3 cycles.
- LH x4,2(x0) with mem word 0x8001_0000, rvalid 2 cycles after ready -> x4=0xFFFF8001.
- LW at addr 0x6 -> exception=1, no dmem_req, x rd unchanged; reset low mid-REQ -> dmem_req=0 same cycle, all outputs 0.
